// File: rtl/mem_arbiter_pkg.sv
// mem_arbiter_pkg
//   Shared definitions for the instruction/data memory arbiter.
//   - owner_t        : which requester owns the read data returning this cycle
//   - STARVE_MAX_DEF : default bound on consecutive data grants while a
//                      fetch is waiting
package mem_arbiter_pkg;

    typedef enum logic [1:0] {
        OWN_NONE = 2'd0,
        OWN_IF   = 2'd1,
        OWN_DATA = 2'd2
    } owner_t;

    localparam int STARVE_MAX_DEF = 4;

endpackage

// File: rtl/mem_arbiter.sv
// mem_arbiter
//   Arbitrates one single-port RAM between an instruction-fetch port and a
//   data port. Grants are combinational in the request cycle; read data comes
//   back one cycle later and is routed to whichever port owned the access.
//   Data normally wins ties, but after STARVE_MAX consecutive data grants
//   with a fetch waiting, the fetch is given the next slot.
//
// Ports
//   clk, rst                 : clock, synchronous active-high reset
//   if_req_i, if_addr_i      : fetch request / byte address
//   if_gnt_o, if_rvalid_o,
//   if_rdata_o               : fetch grant, read-data valid, read data
//   d_req_i, d_we_i, d_sel_i,
//   d_addr_i, d_wdata_i      : data request / store enable / lanes / addr / wdata
//   d_gnt_o, d_rvalid_o,
//   d_rdata_o                : data grant, read-data valid, read data
//   m_ce_o, m_we_o, m_sel_o,
//   m_addr_o, m_wdata_o,
//   m_rdata_i                : shared RAM port (rdata valid one cycle after read)
//   stallreq_o               : a request is waiting this cycle
module mem_arbiter
    import mem_arbiter_pkg::*;
#(
    parameter int STARVE_MAX = STARVE_MAX_DEF
) (
    input  logic        clk,
    input  logic        rst,

    input  logic        if_req_i,
    input  logic [31:0] if_addr_i,
    output logic        if_gnt_o,
    output logic        if_rvalid_o,
    output logic [31:0] if_rdata_o,

    input  logic        d_req_i,
    input  logic        d_we_i,
    input  logic [3:0]  d_sel_i,
    input  logic [31:0] d_addr_i,
    input  logic [31:0] d_wdata_i,
    output logic        d_gnt_o,
    output logic        d_rvalid_o,
    output logic [31:0] d_rdata_o,

    output logic        m_ce_o,
    output logic        m_we_o,
    output logic [3:0]  m_sel_o,
    output logic [31:0] m_addr_o,
    output logic [31:0] m_wdata_o,
    input  logic [31:0] m_rdata_i,

    output logic        stallreq_o
);

    localparam int CW = (STARVE_MAX < 1) ? 1 : $clog2(STARVE_MAX + 1);

    owner_t        r_owner;
    logic [CW-1:0] r_starve_cnt;

    logic w_starved;
    logic w_if_gnt;
    logic w_d_gnt;

    // Fetch only wins a tie once data has hogged the RAM for STARVE_MAX cycles.
    assign w_starved = (r_starve_cnt == CW'(STARVE_MAX));
    assign w_if_gnt  = ~rst & if_req_i & (~d_req_i | w_starved);
    assign w_d_gnt   = ~rst & d_req_i & ~w_if_gnt;

    assign if_gnt_o   = w_if_gnt;
    assign d_gnt_o    = w_d_gnt;
    assign stallreq_o = ~rst & ((if_req_i & ~w_if_gnt) | (d_req_i & ~w_d_gnt));

    // Response routing; gated by rst so a read issued just before reset
    // never surfaces.
    assign if_rvalid_o = ~rst & (r_owner == OWN_IF);
    assign d_rvalid_o  = ~rst & (r_owner == OWN_DATA);
    assign if_rdata_o  = if_rvalid_o ? m_rdata_i : 32'h0;
    assign d_rdata_o   = d_rvalid_o  ? m_rdata_i : 32'h0;

    always_comb begin
        m_ce_o    = 1'b0;
        m_we_o    = 1'b0;
        m_sel_o   = 4'h0;
        m_addr_o  = 32'h0;
        m_wdata_o = 32'h0;
        if (w_if_gnt) begin
            m_ce_o   = 1'b1;
            m_sel_o  = 4'hF;
            m_addr_o = if_addr_i;
        end else if (w_d_gnt) begin
            m_ce_o    = 1'b1;
            m_we_o    = d_we_i;
            m_sel_o   = d_sel_i;
            m_addr_o  = d_addr_i;
            m_wdata_o = d_wdata_i;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_owner      <= OWN_NONE;
            r_starve_cnt <= '0;
        end else begin
            // Stores complete in the grant cycle, so they leave no owner.
            if (w_if_gnt)
                r_owner <= OWN_IF;
            else if (w_d_gnt && !d_we_i)
                r_owner <= OWN_DATA;
            else
                r_owner <= OWN_NONE;

            if (w_if_gnt || !if_req_i)
                r_starve_cnt <= '0;
            else if (w_d_gnt && !w_starved)
                r_starve_cnt <= r_starve_cnt + 1'b1;
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter
//   Scenario tasks drive requests and check the combinational grant / RAM
//   outputs in the request cycle. Every read expected to be granted pushes
//   its expected owner and data onto a scoreboard; a negedge monitor pops
//   and checks the response one cycle later and requires silence otherwise.
module tb_mem_arbiter;

    logic        clk;
    logic        rst;
    logic        if_req_i;
    logic [31:0] if_addr_i;
    logic        if_gnt_o, if_rvalid_o;
    logic [31:0] if_rdata_o;
    logic        d_req_i, d_we_i;
    logic [3:0]  d_sel_i;
    logic [31:0] d_addr_i, d_wdata_i;
    logic        d_gnt_o, d_rvalid_o;
    logic [31:0] d_rdata_o;
    logic        m_ce_o, m_we_o;
    logic [3:0]  m_sel_o;
    logic [31:0] m_addr_o, m_wdata_o;
    logic [31:0] m_rdata_i;
    logic        stallreq_o;

    mem_arbiter #(.STARVE_MAX(4)) dut (
        .clk(clk), .rst(rst),
        .if_req_i(if_req_i), .if_addr_i(if_addr_i),
        .if_gnt_o(if_gnt_o), .if_rvalid_o(if_rvalid_o), .if_rdata_o(if_rdata_o),
        .d_req_i(d_req_i), .d_we_i(d_we_i), .d_sel_i(d_sel_i),
        .d_addr_i(d_addr_i), .d_wdata_i(d_wdata_i),
        .d_gnt_o(d_gnt_o), .d_rvalid_o(d_rvalid_o), .d_rdata_o(d_rdata_o),
        .m_ce_o(m_ce_o), .m_we_o(m_we_o), .m_sel_o(m_sel_o),
        .m_addr_o(m_addr_o), .m_wdata_o(m_wdata_o), .m_rdata_i(m_rdata_i),
        .stallreq_o(stallreq_o)
    );

    typedef struct {
        int          due;
        bit          is_if;
        logic [31:0] data;
    } exp_t;

    exp_t sbq[$];
    int   total = 0;
    int   bad   = 0;
    int   cyc   = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [31:0] rd_val(input logic [31:0] a);
        if (a == 32'h100) return 32'h0000_0013;
        return {a[15:0], ~a[15:0]};
    endfunction

    // RAM model: read data valid exactly one cycle after a read access,
    // junk otherwise so unrouted data is visible.
    always @(posedge clk) begin
        if (m_ce_o && !m_we_o) m_rdata_i <= rd_val(m_addr_o);
        else                   m_rdata_i <= 32'hBAD0_BAD0;
    end

    // Response scoreboard.
    always @(negedge clk) begin
        bit          e_if, e_d;
        logic [31:0] e_data;
        exp_t        e;
        e_if = 0; e_d = 0; e_data = 32'h0;
        if (sbq.size() > 0 && sbq[0].due == cyc) begin
            e = sbq.pop_front();
            e_if = e.is_if; e_d = !e.is_if; e_data = e.data;
        end
        total++;
        if (if_rvalid_o !== e_if || d_rvalid_o !== e_d) begin
            bad++;
            $display("FAIL rvalid cyc=%0d: got if=%b d=%b, want if=%b d=%b",
                     cyc, if_rvalid_o, d_rvalid_o, e_if, e_d);
        end
        if (e_if || e_d) begin
            total++;
            if (if_rdata_o !== (e_if ? e_data : 32'h0) ||
                d_rdata_o  !== (e_d  ? e_data : 32'h0)) begin
                bad++;
                $display("FAIL rdata cyc=%0d: got if=%h d=%h, want %s=%h other=0",
                         cyc, if_rdata_o, d_rdata_o, e_if ? "if" : "d", e_data);
            end
        end
    end

    task automatic drv(input bit ifr, input logic [31:0] ifa, input bit dr,
                       input bit we, input logic [3:0] sel,
                       input logic [31:0] da, input logic [31:0] wd);
        if_req_i = ifr; if_addr_i = ifa;
        d_req_i = dr; d_we_i = we; d_sel_i = sel; d_addr_i = da; d_wdata_i = wd;
    endtask

    task automatic next_cycle();
        @(posedge clk); #1;
    endtask

    task automatic push(input bit is_if, input logic [31:0] a);
        exp_t e;
        e.due = cyc + 1; e.is_if = is_if; e.data = rd_val(a);
        sbq.push_back(e);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) begin
            next_cycle();
            drv(1, 32'h40, 1, 0, 4'hF, 32'h44, 32'h0); #1;
            total++;
            if ({if_gnt_o, d_gnt_o, m_ce_o, stallreq_o, if_rvalid_o, d_rvalid_o} !== 6'b0) begin
                bad++;
                $display("FAIL reset_outputs: got gi=%b gd=%b ce=%b st=%b rvi=%b rvd=%b, want all 0",
                         if_gnt_o, d_gnt_o, m_ce_o, stallreq_o, if_rvalid_o, d_rvalid_o);
            end
        end
        next_cycle();
        rst = 1'b0;
        drv(0, 32'h40, 0, 1, 4'h5, 32'h44, 32'h1234); #1;
        total++;
        if ({m_ce_o, m_we_o, m_sel_o, m_addr_o, m_wdata_o, if_gnt_o, d_gnt_o, stallreq_o} !== 73'b0) begin
            bad++;
            $display("FAIL idle_bus: got ce=%b we=%b sel=%h addr=%h wd=%h, want all 0",
                     m_ce_o, m_we_o, m_sel_o, m_addr_o, m_wdata_o);
        end
    endtask

    task automatic test_fetch_only();
        next_cycle();
        drv(1, 32'h100, 0, 0, 4'h0, 32'h0, 32'h0); #1;
        total++;
        if (if_gnt_o !== 1 || d_gnt_o !== 0 || m_ce_o !== 1 || m_we_o !== 0 ||
            m_sel_o !== 4'hF || m_addr_o !== 32'h100 || m_wdata_o !== 0 || stallreq_o !== 0) begin
            bad++;
            $display("FAIL fetch_only: got gi=%b gd=%b ce=%b we=%b sel=%h addr=%h st=%b, want 1 0 1 0 f 100 0",
                     if_gnt_o, d_gnt_o, m_ce_o, m_we_o, m_sel_o, m_addr_o, stallreq_o);
        end
        push(1, 32'h100);
        next_cycle();
        drv(0, 32'h0, 0, 0, 4'h0, 32'h0, 32'h0);
    endtask

    task automatic test_priority();
        next_cycle();
        drv(1, 32'h104, 1, 0, 4'hF, 32'h2000, 32'h0); #1;
        total++;
        if (d_gnt_o !== 1 || if_gnt_o !== 0 || stallreq_o !== 1 || m_addr_o !== 32'h2000) begin
            bad++;
            $display("FAIL tie_data_wins: got gd=%b gi=%b st=%b addr=%h, want 1 0 1 2000",
                     d_gnt_o, if_gnt_o, stallreq_o, m_addr_o);
        end
        push(0, 32'h2000);
        next_cycle();
        drv(1, 32'h104, 0, 0, 4'h0, 32'h0, 32'h0); #1;
        total++;
        if (if_gnt_o !== 1 || d_gnt_o !== 0 || stallreq_o !== 0 || m_addr_o !== 32'h104) begin
            bad++;
            $display("FAIL fetch_follows: got gi=%b gd=%b st=%b addr=%h, want 1 0 0 104",
                     if_gnt_o, d_gnt_o, stallreq_o, m_addr_o);
        end
        push(1, 32'h104);
        next_cycle();
        drv(0, 32'h0, 0, 0, 4'h0, 32'h0, 32'h0);
    endtask

    task automatic test_store();
        next_cycle();
        drv(0, 32'h0, 1, 1, 4'b0011, 32'h2004, 32'hDEADBEEF); #1;
        total++;
        if (d_gnt_o !== 1 || m_ce_o !== 1 || m_we_o !== 1 || m_sel_o !== 4'b0011 ||
            m_addr_o !== 32'h2004 || m_wdata_o !== 32'hDEADBEEF) begin
            bad++;
            $display("FAIL store: got gd=%b ce=%b we=%b sel=%h addr=%h wd=%h, want 1 1 1 3 2004 deadbeef",
                     d_gnt_o, m_ce_o, m_we_o, m_sel_o, m_addr_o, m_wdata_o);
        end
        next_cycle();
        drv(0, 32'h0, 0, 0, 4'h0, 32'h0, 32'h0); #1;
        total++;
        if (d_rvalid_o !== 0) begin
            bad++;
            $display("FAIL store_no_rvalid: got d_rvalid=%b, want 0", d_rvalid_o);
        end
    endtask

    task automatic test_starve();
        for (int i = 1; i <= 6; i++) begin
            bit          exp_if;
            logic [31:0] da;
            exp_if = (i == 5);
            da = 32'h3000 + 32'(4 * i);
            next_cycle();
            drv(i <= 5, 32'h400, 1, 0, 4'hF, da, 32'h0); #1;
            total++;
            if (if_gnt_o !== exp_if || d_gnt_o !== !exp_if || stallreq_o !== (i <= 5)) begin
                bad++;
                $display("FAIL starve_c%0d: got gi=%b gd=%b st=%b, want %b %b %b",
                         i, if_gnt_o, d_gnt_o, stallreq_o, exp_if, !exp_if, (i <= 5));
            end
            push(exp_if, exp_if ? 32'h400 : da);
        end
        next_cycle();
        drv(0, 32'h0, 0, 0, 4'h0, 32'h0, 32'h0);
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i < 8; i++) begin
            bit          f;
            logic [31:0] a;
            f = (i % 2 == 0);
            a = f ? 32'h500 + 32'(4 * i) : 32'h6000 + 32'(4 * i);
            next_cycle();
            drv(f, a, !f, 0, 4'hF, a, 32'h0); #1;
            total++;
            if (if_gnt_o !== f || d_gnt_o !== !f || m_addr_o !== a) begin
                bad++;
                $display("FAIL alt_c%0d: got gi=%b gd=%b addr=%h, want %b %b %h",
                         i, if_gnt_o, d_gnt_o, m_addr_o, f, !f, a);
            end
            push(f, a);
        end
        next_cycle();
        drv(0, 32'h0, 0, 0, 4'h0, 32'h0, 32'h0);
    endtask

    task automatic test_reset_mid_read();
        next_cycle();
        drv(1, 32'h800, 1, 0, 4'hF, 32'h7000, 32'h0); #1;
        total++;
        if (d_gnt_o !== 1 || if_gnt_o !== 0) begin
            bad++;
            $display("FAIL pre_reset_read: got gd=%b gi=%b, want 1 0", d_gnt_o, if_gnt_o);
        end
        next_cycle();
        rst = 1'b1; #1;
        total++;
        if (d_rvalid_o !== 0 || d_gnt_o !== 0 || if_gnt_o !== 0 || stallreq_o !== 0) begin
            bad++;
            $display("FAIL in_reset: got rvd=%b gd=%b gi=%b st=%b, want 0 0 0 0",
                     d_rvalid_o, d_gnt_o, if_gnt_o, stallreq_o);
        end
        next_cycle();
        rst = 1'b0;
        drv(0, 32'h0, 0, 0, 4'h0, 32'h0, 32'h0); #1;
        total++;
        if (dut.r_owner !== 2'd0 || dut.r_starve_cnt !== 0 || d_rvalid_o !== 0) begin
            bad++;
            $display("FAIL post_reset_state: got owner=%0d starve=%0d rvd=%b, want 0 0 0",
                     dut.r_owner, dut.r_starve_cnt, d_rvalid_o);
        end
    endtask

    initial begin
        rst = 1'b1;
        drv(0, 32'h0, 0, 0, 4'h0, 32'h0, 32'h0);
        test_reset();
        test_fetch_only();
        test_priority();
        test_store();
        test_starve();
        test_back_to_back();
        test_reset_mid_read();
        repeat (3) next_cycle();
        total++;
        if (sbq.size() != 0) begin
            bad++;
            $display("FAIL scoreboard_drain: got %0d pending, want 0", sbq.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 SHALL have parameter STARVE_MAX, default 4, max consecutive data grants while a fetch waits.
REQ-002 SHALL have port clk  input  1  single clock for the whole block; all state updates on the rising edge.
REQ-003 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-004 SHALL have port if_req_i  input  1  instruction-fetch read request.
REQ-005 SHALL have port if_addr_i  input  32  fetch byte address.
REQ-006 SHALL have ports if_gnt_o  output  1  and if_rvalid_o  output  1: fetch accepted this cycle, and fetch read data valid.
REQ-007 SHALL have port if_rdata_o  output  32  fetch read data.
REQ-008 SHALL have ports d_req_i, d_we_i  input  1: data request and write enable (1 = store).
REQ-009 SHALL have ports d_sel_i  input  4  byte lanes, d_addr_i  input  32, d_wdata_i  input  32.
REQ-010 SHALL have ports d_gnt_o, d_rvalid_o  output  1 and d_rdata_o  output  32 (data-side equivalents of REQ-006/007).
REQ-011 SHALL have ports m_ce_o, m_we_o  output  1, m_sel_o  output  4, m_addr_o, m_wdata_o  output  32: shared single-port RAM.
REQ-012 SHALL have port m_rdata_i  input  32  RAM read data, valid exactly one cycle after a read access.
REQ-013 SHALL have port stallreq_o  output  1  pipeline stall request to ctrl.

Function
REQ-014 Grant SHALL be combinational in the request cycle; at most one of if_gnt_o/d_gnt_o high per cycle.
REQ-015 Only data requesting: d_gnt_o=1. Only fetch requesting: if_gnt_o=1. Neither: no grant, m_ce_o=0.
REQ-016 Both requesting: data wins unless starve_cnt == STARVE_MAX, in which case fetch wins.
REQ-017 starve_cnt SHALL increment on each cycle data is granted while if_req_i=1, saturating at STARVE_MAX.
REQ-018 starve_cnt SHALL clear whenever fetch is granted or if_req_i=0.
REQ-019 On grant, m_ce_o=1 and m_addr_o/m_we_o/m_sel_o/m_wdata_o SHALL carry the winner's fields; fetch grants drive m_we_o=0, m_sel_o=4'hF, m_wdata_o=0.
REQ-020 With no grant, m_we_o, m_sel_o, m_addr_o and m_wdata_o SHALL be 0.
REQ-021 Registered owner state SHALL be one of NONE, IF, DATA: the next state is IF after a fetch grant, DATA after a data read grant, and NONE otherwise, including writes and idle cycles.
REQ-022 When owner=IF, if_rvalid_o=1 and if_rdata_o=m_rdata_i. When owner=DATA, d_rvalid_o=1 and d_rdata_o=m_rdata_i. Non-owned rdata outputs SHALL be 0.
REQ-023 Back-to-back accesses SHALL be pipelined: a new grant may issue in the same cycle a prior response returns, giving one access per cycle throughput.
REQ-024 Read latency SHALL be exactly 1 cycle from grant to rvalid; writes produce no rvalid and complete in the grant cycle.
REQ-025 stallreq_o SHALL be (if_req_i & ~if_gnt_o) | (d_req_i & ~d_gnt_o).
REQ-026 A requester SHALL hold its request and fields stable until granted; the arbiter keeps no request queue.

Reset
REQ-027 While rst=1 at a clock edge, owner SHALL become NONE and starve_cnt SHALL become 0.
REQ-028 While rst=1, all grants, rvalids, m_ce_o and stallreq_o SHALL be 0 regardless of requests.
REQ-029 A read granted in the cycle before reset SHALL NOT produce an rvalid after reset.

Structure
REQ-030 Owner encodings (NONE=2'd0, IF=2'd1, DATA=2'd2) and the STARVE_MAX default SHALL live in the shared core defines file.
REQ-031 The block SHALL be a single module with no sub-modules.
REQ-032 It SHALL sit between bitty_riscv's rom/ram ports and one RAM, with stallreq_o ORed into ctrl's stall request.

Verification
REQ-033 A bench SHALL cover: fetch only, addr 0x100 with m_rdata_i=0x00000013 -> if_gnt_o=1 at cycle 0, if_rvalid_o=1 with if_rdata_o=0x00000013 at cycle 1.
REQ-034 A bench SHALL cover: simultaneous fetch 0x104 and data read 0x2000 -> d_gnt_o=1, if_gnt_o=0, stallreq_o=1; fetch granted the next cycle.
REQ-035 A bench SHALL cover: data store 0x2004, sel=4'b0011, wdata=0xDEADBEEF -> m_we_o=1, m_sel_o=4'b0011 in the grant cycle; no d_rvalid_o afterwards.
REQ-036 A bench SHALL cover: d_req_i held high for 6 cycles with fetch pending -> data granted 4 times, fetch granted on cycle 5, data on cycle 6.
REQ-037 A bench SHALL cover: alternating fetch/data reads every cycle -> one rvalid per cycle, each routed to the correct owner.
REQ-038 A bench SHALL cover: data read granted, rst=1 the next cycle -> d_rvalid_o=0, owner=NONE, starve_cnt=0.
